// File: rtl/column_prefetch_if.sv
// column_prefetch_if: groups the column prefetch's request inputs (theta, frame),
//   its texture ROM port and its pixel-read port towards neopixel_controller.
// Signals: theta/frame_idx (column request), rom_addr/rom_data (texture ROM),
//   next_px_num/pixel (pixel read), col_ready/front_col (status).
// master = surrounding system (angle_mapper, ROM, neopixel_controller);
//   slave = column_prefetch.
interface column_prefetch_if #(
  parameter int PX_BITS   = 24,
  parameter int ADDR_BITS = 17
);
  logic [5:0]           theta;
  logic [7:0]           frame_idx;
  logic [ADDR_BITS-1:0] rom_addr;
  logic [PX_BITS-1:0]   rom_data;
  logic [5:0]           next_px_num;
  logic [PX_BITS-1:0]   pixel;
  logic                 col_ready;
  logic [5:0]           front_col;

  modport master (
    output theta, frame_idx, rom_data, next_px_num,
    input  rom_addr, pixel, col_ready, front_col
  );

  modport slave (
    input  theta, frame_idx, rom_data, next_px_num,
    output rom_addr, pixel, col_ready, front_col
  );
endinterface

// File: rtl/column_prefetch.sv
// column_prefetch: double-buffers one texture column (LED_COUNT pixels) and swaps
//   it to the front only when the strip read wraps to pixel 0.
// Latency: pixel is registered, 1 cycle after next_px_num. A fill takes
//   LED_COUNT+ROM_LATENCY cycles after the request is latched.
// Backpressure: none. The ROM answers with fixed latency and pixel reads are
//   always served. A new request aborts any fill in progress.
// Ports: clk_i, reset_i (sync, active-high); bus_io (column_prefetch_if.slave);
//   drop_count_o (16b) only when COLUMN_PREFETCH_DROP_CNT_EN is defined.
// Optional macro COLUMN_PREFETCH_DROP_CNT_EN adds a saturating counter of fills
//   thrown away before they were ever displayed.
module column_prefetch #(
  parameter int LED_COUNT   = 52,
  parameter int TEX_WIDTH   = 64,
  parameter int NUM_FRAMES  = 30,
  parameter int PX_BITS     = 24,
  parameter int ADDR_BITS   = 17,
  parameter int ROM_LATENCY = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  column_prefetch_if.slave   bus_io
`ifdef COLUMN_PREFETCH_DROP_CNT_EN
  ,
  output logic [15:0]        drop_count_o
`endif
);

  localparam int IDX_BITS  = $clog2(LED_COUNT);
  localparam int CNT_BITS  = $clog2(LED_COUNT + ROM_LATENCY + 1);
  localparam int FILL_LAST = LED_COUNT + ROM_LATENCY - 1;

  localparam logic [ADDR_BITS-1:0] FRAME_STRIDE = ADDR_BITS'(TEX_WIDTH * LED_COUNT);
  localparam logic [ADDR_BITS-1:0] ROW_STRIDE   = ADDR_BITS'(TEX_WIDTH);
  localparam logic [7:0]           NUM_FRAMES_B = 8'(NUM_FRAMES);
  localparam logic [5:0]           LED_COUNT_PX = 6'(LED_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Request tracking
  logic                 last_vld_q;
  logic [5:0]           last_theta_q;
  logic [7:0]           last_frame_q;
  logic [5:0]           fill_col_q;

  // Fill sequencing
  logic [ADDR_BITS-1:0] addr_q;
  logic [CNT_BITS-1:0]  cyc_q;
  logic                 pipe_vld_q [ROM_LATENCY];
  logic [IDX_BITS-1:0]  pipe_idx_q [ROM_LATENCY];

  // Front buffer / read side
  logic                 front_sel_q;
  logic                 front_vld_q;
  logic [5:0]           front_col_q;
  logic [PX_BITS-1:0]   pixel_q;
  logic [5:0]           prev_px_q;

  logic [PX_BITS-1:0]   mem_q [2][LED_COUNT];

  // Combinational helpers
  logic                 req;
  logic                 swap_evt;
  logic                 issue;
  logic [ADDR_BITS-1:0] frame_c;
  logic [ADDR_BITS-1:0] fill_base;
  logic                 fill_start;
  logic                 swap_take;
  logic                 front_sel_d;
  logic                 front_vld_d;
  logic                 rd_ok;
  logic [ADDR_BITS-1:0] rom_addr;
  logic                 col_ready;

  // A request is any change of column or frame against what was last latched;
  // the invalid flag after reset forces the very first fill.
  assign req = !last_vld_q
             || (bus_io.theta != last_theta_q)
             || (bus_io.frame_idx != last_frame_q);

  // Strip wrap: the controller's pixel index drops from nonzero back to 0.
  assign swap_evt = (prev_px_q != 6'd0) && (bus_io.next_px_num == 6'd0);

  // Only the first LED_COUNT cycles of a fill issue addresses; the remaining
  // ROM_LATENCY cycles just drain the returning data.
  assign issue = (state_q == ST_FILL) && (cyc_q < CNT_BITS'(LED_COUNT));

  // Out-of-range frames read frame 0. The raw value is still what gets
  // compared against, so a steady out-of-range input does not refill forever.
  assign frame_c   = (bus_io.frame_idx < NUM_FRAMES_B) ? ADDR_BITS'(bus_io.frame_idx) : '0;
  assign fill_base = frame_c * FRAME_STRIDE + ADDR_BITS'(bus_io.theta);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_FILL;
      end
      ST_FILL: begin
        // A request restarts the fill; wraps are ignored while filling.
        if (req) begin
          state_d = ST_FILL;
        end else if (cyc_q == CNT_BITS'(FILL_LAST)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // The swap takes priority. A simultaneous request is latched in the
        // same cycle and fills the buffer that has just become the back one.
        if (swap_evt) begin
          state_d = req ? ST_FILL : ST_IDLE;
        end else if (req) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    fill_start = req;
    swap_take  = (state_q == ST_READY) && swap_evt;
    col_ready  = (state_q == ST_READY);
    rom_addr   = issue ? addr_q : '0;
  end

  // In a swap cycle the pixel read already sees the new front buffer.
  assign front_sel_d = swap_take ? ~front_sel_q : front_sel_q;
  assign front_vld_d = swap_take | front_vld_q;
  assign rd_ok       = front_vld_d && (bus_io.next_px_num < LED_COUNT_PX);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_vld_q   <= 1'b0;
      last_theta_q <= '0;
      last_frame_q <= '0;
      fill_col_q   <= '0;
      addr_q       <= '0;
      cyc_q        <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_idx_q[k] <= '0;
      end
      front_sel_q  <= 1'b0;
      front_vld_q  <= 1'b0;
      front_col_q  <= '0;
      pixel_q      <= '0;
      prev_px_q    <= '0;
    end else begin
      prev_px_q <= bus_io.next_px_num;

      if (fill_start) begin
        last_vld_q   <= 1'b1;
        last_theta_q <= bus_io.theta;
        last_frame_q <= bus_io.frame_idx;
        fill_col_q   <= bus_io.theta;
        addr_q       <= fill_base;
        cyc_q        <= '0;
      end else begin
        if (issue) addr_q <= addr_q + ROW_STRIDE;
        if ((state_q == ST_FILL) && (cyc_q != CNT_BITS'(FILL_LAST))) begin
          cyc_q <= cyc_q + 1'b1;
        end
      end

      // Tracks which back-buffer slot each in-flight ROM read belongs to.
      // A restart flushes it so stale reads from the old column are not counted.
      pipe_vld_q[0] <= issue && !fill_start;
      pipe_idx_q[0] <= IDX_BITS'(cyc_q);
      for (int k = 1; k < ROM_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1] && !fill_start;
        pipe_idx_q[k] <= pipe_idx_q[k-1];
      end

      if (swap_take) begin
        front_sel_q <= ~front_sel_q;
        front_vld_q <= 1'b1;
        front_col_q <= fill_col_q;
      end

      pixel_q <= rd_ok ? mem_q[front_sel_d][bus_io.next_px_num] : '0;
    end
  end

  // Buffer storage, no reset: contents are only exposed after a complete fill.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_FILL) && pipe_vld_q[ROM_LATENCY-1]) begin
      mem_q[~front_sel_q][pipe_idx_q[ROM_LATENCY-1]] <= bus_io.rom_data;
    end
  end

`ifdef COLUMN_PREFETCH_DROP_CNT_EN
  // Counts completed-or-partial back buffers discarded before ever being shown:
  // a restart during a fill, or a new request overwriting a READY buffer.
  logic        drop_inc;
  logic [15:0] drop_cnt_q;

  assign drop_inc = req && ((state_q == ST_FILL) || ((state_q == ST_READY) && !swap_evt));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign bus_io.rom_addr  = rom_addr;
  assign bus_io.pixel     = pixel_q;
  assign bus_io.col_ready = col_ready;
  assign bus_io.front_col = front_col_q;

endmodule
